mul_seq_ctrl: RTL and testbench
===============================

// Module: mul_seq_ctrl
// PURPOSE
//  Sequencer for a multi-cycle 32x32 shift-add multiplier. It replaces the combinational product path.
//  Accepts one operand pair per start/ready handshake and iterates radix-2 add/shift steps.
//  Applies a signed correction and then presents both products: Z (unsigned) and Y (two's-complement signed).
//  Sits between the ALU operand registers and the result mux; one operation in flight at a time.
// PARAMETERS
//  WIDTH  32  operand width; products are 2*WIDTH bits; iteration count = WIDTH
// PORTS
//  clk    in   1        rising-edge clock
//  rst    in   1        synchronous, active-high reset
//  start  in   1        request; accepted only in the cycle where ready=1
//  A      in   WIDTH    multiplicand; sampled on accept
//  B      in   WIDTH    multiplier; sampled on accept
//  ready  out  1        1 only in IDLE
//  busy   out  1        1 in RUN and FIX
//  done   out  1        single-cycle pulse; Z/Y valid from this cycle onward
//  Z      out  2*WIDTH  unsigned product A*B
//  Y      out  2*WIDTH  signed product $signed(A)*$signed(B)
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=IDLE, ready=1, busy=0, done=0, Z=0, Y=0, iteration counter=0.
//  States: IDLE -> RUN -> FIX -> DONE -> IDLE.
//  IDLE: start=1 latches A and B, clears the accumulator and counter, then goes to RUN. start=0 stays in IDLE.
//  RUN, one step per cycle for WIDTH cycles:
//   - if multiplier LSB=1, acc_hi += multiplicand, using a (WIDTH+1)-bit add that keeps the carry;
//   - {carry, acc} >>= 1, and the multiplier shifts right;
//   - counter increments; counter==WIDTH-1 -> FIX.
//  FIX, one cycle:
//   - Z <= acc;
//   - Y <= acc - (A[W-1] ? B<<W : 0) - (B[W-1] ? A<<W : 0), mod 2^(2W).
//   - Uses the latched A and B, not the live ports.
//  DONE: done=1 for exactly this cycle, then IDLE.
//  Latency: accept at cycle t -> done=1 at cycle t+WIDTH+2 (t+34 for WIDTH=32). Throughput: one op per WIDTH+3 cycles.
//  Z/Y hold their values from FIX until the next FIX or rst. They do not change on accept.
//  start while ready=0 is ignored. No queueing, no error flag.
//  A/B changing after accept have no effect on the op in flight.
//  rst mid-RUN/FIX/DONE: aborts immediately, drops the pending done, zeroes outputs, ready=1 next cycle.
//  rst and start in the same cycle: rst wins; start is not accepted.
//  Zero operand: still takes the full WIDTH+2 latency; Z=Y=0 (no early exit).
//  All arithmetic is unsigned internally; carry-out of the add must not be lost (bit WIDTH of the adder).
// STRUCTURE
//  Shared package mul_pkg:
//   - state enum {IDLE,RUN,FIX,DONE} (2-bit encoding);
//   - localparam for counter width = $clog2(WIDTH).
//  Sub-module mul_step: combinational, one add/shift iteration.
//   - in: acc, mcand, mplier_lsb; out: next acc. Instanced once.
//  The top module holds the FSM, counter, operand/acc registers and the FIX correction.
// TESTING (check done timing, ready/busy per cycle, Z and Y)
//  1. A=3, B=5; start 1 cycle -> ready low the next cycle; done at t+34; Z=Y=64'h0F.
//  2. A=32'hFFFFFFFF, B=32'hFFFFFFFF -> Z=64'hFFFFFFFE_00000001, Y=64'h1.
//  3. A=32'h80000000, B=32'h80000000 -> Z=Y=64'h40000000_00000000.
//     Then A=32'hFFFFFFFF, B=2 -> Z=64'h1_FFFFFFFE, Y=64'hFFFFFFFF_FFFFFFFE.
//  4. Accept A=7, B=9; pulse start with A=1, B=1 at t+5 and change A/B.
//     -> second start ignored; done only at t+34; Z=Y=63.
//  5. Accept A=3, B=5; assert rst at t+10 for 1 cycle -> done never pulses.
//     Z=Y=0, ready=1 after reset; a new op A=2, B=2 then yields Z=Y=4.
//  6. A=0, B=32'hDEADBEEF -> done at t+34, Z=Y=0.
//     Back-to-back: start held high -> next accept exactly at t+35.

Source files
------------

// File: rtl/mul_pkg.sv
// mul_pkg: shared state type and sizes for the sequential shift-add multiplier
package mul_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int CNT_W = $clog2(DEF_WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
endpackage

// File: rtl/mul_step.sv
// mul_step: one radix-2 add/shift iteration of the unsigned accumulator
module mul_step
  import mul_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   mcand,
  input  logic               mplier_lsb,
  output logic [2*WIDTH-1:0] acc_nx
);
  logic [WIDTH:0] sum;
  // add into the upper half keeping the carry, then shift the whole {carry, acc} right by one
  always_comb begin
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier_lsb ? {1'b0, mcand} : '0);
    acc_nx = (2*WIDTH)'({sum, acc[WIDTH-1:0]} >> 1);
  end
endmodule

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: sequencer for a multi-cycle shift-add multiplier producing unsigned and signed products
module mul_seq_ctrl
  import mul_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] Z,
  output logic [2*WIDTH-1:0] Y
);
  state_t state, state_nx;
  logic [WIDTH-1:0] a_r, b_r, m_r;
  logic [2*WIDTH-1:0] acc, acc_nx, y_fix;
  logic [CNT_W-1:0] cnt;
  logic accept;
  mul_step #(.WIDTH(WIDTH)) u_step (
    .acc(acc),
    .mcand(a_r),
    .mplier_lsb(m_r[0]),
    .acc_nx(acc_nx)
  );
  assign accept = ready && start;
  // signed product from the unsigned one: subtract each operand shifted up when the other is negative
  assign y_fix = acc - (a_r[WIDTH-1] ? {b_r, {WIDTH{1'b0}}} : '0)
                     - (b_r[WIDTH-1] ? {a_r, {WIDTH{1'b0}}} : '0);
  // state register
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  // next state and status outputs
  always_comb begin
    state_nx = state;
    ready = state == IDLE;
    busy = state == RUN || state == FIX;
    done = state == DONE;
    case (state)
      IDLE: state_nx = start ? RUN : IDLE;
      RUN: state_nx = cnt == CNT_W'(WIDTH - 1) ? FIX : RUN;
      FIX: state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end
  // operand capture, iteration and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r <= '0;
      b_r <= '0;
      m_r <= '0;
      acc <= '0;
      cnt <= '0;
      Z <= '0;
      Y <= '0;
    end else if (accept) begin
      a_r <= A;
      b_r <= B;
      m_r <= B;
      acc <= '0;
      cnt <= '0;
    end else if (state == RUN) begin
      acc <= acc_nx;
      m_r <= m_r >> 1;
      cnt <= cnt + 1'b1;
    end else if (state == FIX) begin
      Z <= acc;
      Y <= y_fix;
    end
  end
endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb_mul_seq_ctrl: scoreboard bench for the sequential multiplier against an arithmetic reference
module tb_mul_seq_ctrl;
  localparam int W = 32;
  typedef struct {
    logic [63:0] z;
    logic [63:0] y;
    int dc;
  } exp_t;
  logic clk = 0, rst = 1, start = 0;
  logic [W-1:0] A = 0, B = 0;
  logic ready, busy, done;
  logic [2*W-1:0] Z, Y;
  int cyc = 0, vectors = 0, miscompares = 0, last_c0 = 0;
  bit prev_hold = 0;
  logic [63:0] pz = 0, py = 0;
  exp_t q[$];
  exp_t e_m;

  mul_seq_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .ready(ready), .busy(busy), .done(done), .Z(Z), .Y(Y)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at cycle %0d", n, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input int dc);
    exp_t r;
    logic signed [63:0] sa, sb;
    sa = $signed({{32{a[31]}}, a});
    sb = $signed({{32{b[31]}}, b});
    r.z = {32'b0, a} * {32'b0, b};
    r.y = sa * sb;
    r.dc = dc;
    return r;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 4))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      default: return $urandom;
    endcase
  endfunction

  // monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (done) begin
      if (q.size() == 0) chk("done_unexpected", 64'(done), 64'd0);
      else begin
        e_m = q.pop_front();
        chk("done_cycle", 64'(cyc), 64'(e_m.dc));
        chk("Z", Z, e_m.z);
        chk("Y", Y, e_m.y);
      end
    end
  end

  // issue one op at the current negedge and follow it through its whole latency
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit inj, input bit hold);
    int c0, n;
    exp_t ex;
    A = a; B = b; start = 1; n = 0;
    while (!ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      chk("ready_timeout", 64'(ready), 64'd1);
      start = 0;
      return;
    end
    c0 = cyc;
    if (prev_hold) chk("b2b_accept", 64'(c0 - last_c0), 64'd35);
    prev_hold = hold;
    last_c0 = c0;
    ex = model(a, b, c0 + 34);
    q.push_back(ex);
    for (int k = 1; k <= 35; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = hold;
        A = $urandom;
        B = $urandom;
        chk("hold_Z", Z, pz);
        chk("hold_Y", Y, py);
      end
      if (inj && k == 5) begin
        start = 1; A = 1; B = 1;
      end
      if (inj && k == 6) start = 0;
      chk("ready", 64'(ready), 64'(k == 35));
      chk("busy", 64'(busy), 64'(k <= 33));
    end
    chk("done_seen", 64'(q.size()), 64'd0);
    q.delete();
    pz = ex.z;
    py = ex.y;
  endtask

  // accept an op, then reset ten cycles later; no done may follow
  task automatic run_abort(input logic [31:0] a, input logic [31:0] b);
    A = a; B = b; start = 1;
    if (!ready) begin
      chk("abort_ready", 64'(ready), 64'd1);
      start = 0;
      return;
    end
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) start = 0;
    end
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("abort_ready", 64'(ready), 64'd1);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_Z", Z, 64'd0);
    chk("abort_Y", Y, 64'd0);
    repeat (40) @(negedge clk);
    pz = 0;
    py = 0;
    prev_hold = 0;
  endtask

  initial begin
    rst = 1; start = 1; A = 3; B = 5;
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_Z", Z, 64'd0);
    chk("rst_Y", Y, 64'd0);
    rst = 0; start = 0;
    @(negedge clk);
    chk("rst_wins", 64'(ready), 64'd1);
    run_op(32'd3, 32'd5, 0, 0);
    chk("t1_Z", Z, 64'h0F);
    chk("t1_Y", Y, 64'h0F);
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
    chk("t2_Z", Z, 64'hFFFFFFFE_00000001);
    chk("t2_Y", Y, 64'h1);
    run_op(32'h80000000, 32'h80000000, 0, 0);
    chk("t3_Y", Y, 64'h40000000_00000000);
    run_op(32'hFFFFFFFF, 32'd2, 0, 0);
    chk("t3b_Z", Z, 64'h1_FFFFFFFE);
    chk("t3b_Y", Y, 64'hFFFFFFFF_FFFFFFFE);
    run_op(32'd7, 32'd9, 1, 0);
    chk("t4_Z", Z, 64'd63);
    run_abort(32'd3, 32'd5);
    run_op(32'd2, 32'd2, 0, 0);
    chk("t5_Z", Z, 64'd4);
    run_op(32'h0, 32'hDEADBEEF, 0, 1);
    run_op(32'h12345678, 32'h9ABCDEF0, 0, 0);
    for (int i = 0; i < 12; i++) run_op(pick(), pick(), 0, i < 11 ? bit'($urandom_range(0, 1)) : 1'b0);
    start = 0;
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
